dpram_rr_arbiter: RTL and testbench
===================================

Name: dpram_rr_arbiter

Overview:
- Shares one simple dual-port RAM (one write port, one read port, common chip select, registered read data) between two requesters, A and B.
- Arbitrates the write port and the read port independently, each round-robin. A write from one requester and a read from the other are served in the same cycle.
- Routes the registered read data back to the requester that issued the read.
- Sits between the requesters and the RAM instance. It keeps a saturating contention counter for debug.

Parameters:
- DATA_WIDTH, 32, word width; must match the RAM.
- ADDR_WIDTH, 8, address width; must match the RAM.
- CNT_WIDTH, 16, width of the contention counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a_req_valid  in  1  requester A has a request.
- a_req_we  in  1  1 = write, 0 = read.
- a_req_addr  in  ADDR_WIDTH  request address.
- a_req_wdata  in  DATA_WIDTH  write data.
- a_req_ready  out  1  A's request is accepted this cycle.
- a_rsp_valid  out  1  read data for A is valid.
- a_rsp_rdata  out  DATA_WIDTH  read data for A.
- b_req_valid, b_req_we, b_req_addr, b_req_wdata, b_req_ready, b_rsp_valid, b_rsp_rdata  same as A, for requester B.
- mem_cs  out  1  RAM chip select.
- mem_write_en  out  1  RAM write enable.
- mem_write_addr  out  ADDR_WIDTH  RAM write address.
- mem_write_data  out  DATA_WIDTH  RAM write data.
- mem_read_en  out  1  RAM read enable.
- mem_read_addr  out  ADDR_WIDTH  RAM read address.
- mem_read_data  in  DATA_WIDTH  RAM registered read data, valid one cycle after mem_read_en.
- contention_cnt  out  CNT_WIDTH  number of cycles in which either port had two competing requests; saturates.

Behaviour:
- Reset (asynchronous, while rst_n = 0):
  - wr_prio and rd_prio = A.
  - The response pending flag and response id are cleared.
  - contention_cnt = 0.
  - a_rsp_valid and b_rsp_valid = 0 immediately.
  - Any in-flight read is dropped; no response is produced after reset is released.
- Port classification: a request with req_we = 1 competes for the write port; a request with req_we = 0 competes for the read port.
- Grant per port (combinational from valid, we and the priority register):
  - One contender: that contender is granted.
  - Two contenders: the side named by the port's priority register is granted.
- Priority update, per port, on each edge where that port grants: the priority register moves to the requester that was not granted. It holds when the port does not grant.
- req_ready = 1 exactly when that requester is granted on its port. The request transfers when valid && ready.
- Requests are not registered. When a side is not granted, the requester must hold its request stable until ready is asserted.
- RAM drive (combinational from the grant):
  - mem_write_en = write port granted; write address and data come from the write winner.
  - mem_read_en = read port granted; read address comes from the read winner.
  - When a port is idle, its address and data outputs = 0.
  - mem_cs = mem_write_en | mem_read_en.
- Read latency: a read accepted in cycle N gives rsp_valid = 1 in cycle N+1 to the originating requester only.
  - rsp_rdata = mem_read_data, gated to 0 when rsp_valid = 0.
  - Reads are fully pipelined: back-to-back reads give back-to-back responses.
  - There is no response backpressure; the requester must consume rsp_valid in the cycle it is asserted.
- Write and read to the same address in the same cycle: the read returns the old contents (RAM read-before-write). The new data is visible to reads accepted from the next cycle.
- A requester has one request per cycle, so it never writes and reads in the same cycle.
- contention_cnt increments by 1 in every cycle where the write port, the read port, or both have two contenders. It stops at 2^CNT_WIDTH-1 and does not wrap.
- Boundary: addresses 0 and 2^ADDR_WIDTH-1 pass through unmodified. The block does no address checking.

Decomposition:
- Package dpram_arb_pkg holds:
  - requester id constants: REQ_A = 1'b0, REQ_B = 1'b1;
  - a 2-input round-robin grant function that takes the two valids and the priority and returns the winner id plus a grant flag.
- One sub-module is natural: rr_arb2, a 2-way round-robin arbiter containing its own priority register. It is instantiated twice, once for the write port and once for the read port.
- The RAM itself is instantiated outside this block and connected through the mem_* ports.

Test Plan:
- Reset, then A writes 0xDEADBEEF to 0x10, then A reads 0x10 in the next cycle -> each request accepted in the cycle presented; a_rsp_valid = 1 with 0xDEADBEEF exactly one cycle after the read; b_rsp_valid stays 0.
- A and B both write (addr 0x01 and 0x02) and hold valid for 4 cycles -> grants A, B, A, B; contention_cnt = 4; the stalled side's ready stays 0 and its request is held stable.
- In the same cycle, A writes 0x55 to 0x20 and B reads 0x20, where 0x20 previously held 0x11 -> both ready = 1; b_rsp_rdata = 0x11 next cycle; a B read of 0x20 one cycle later returns 0x55; contention_cnt does not increment.
- B issues 3 back-to-back reads of 0x00, 0xFF, 0x7F -> b_rsp_valid high for 3 consecutive cycles with the matching data in order; mem_cs high for those 3 issue cycles.
- Assert rst_n = 0 asynchronously in the cycle after A issues a read -> a_rsp_valid falls immediately; no response after release; priorities back to A; contention_cnt = 0.
- Force continuous two-way contention with CNT_WIDTH = 4 for 20 cycles -> contention_cnt saturates at 15 and holds.

Source files
------------

// File: rtl/dpram_rr_arbiter_pkg.sv
// Shared ids and the 2-way round-robin grant rule used by both RAM port arbiters.
// Pure combinational helpers; no state, no backpressure.
package dpram_arb_pkg;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef struct packed {
    logic vld;
    logic id;
  } rr_gnt_t;

  // A lone contender always wins; a tie goes to the side named by prio.
  function automatic rr_gnt_t rr_grant2(input logic vld_a, input logic vld_b, input logic prio);
    rr_gnt_t g;
    g.vld = vld_a | vld_b;
    if (vld_a && vld_b) begin
      g.id = prio;
    end else if (vld_b) begin
      g.id = REQ_B;
    end else begin
      g.id = REQ_A;
    end
    return g;
  endfunction

endpackage

// File: rtl/dpram_rr_arbiter_if.sv
// Requester A/B request+response signals and the RAM-side signals of the arbiter.
// master = requesters plus RAM; slave = the arbiter.
interface dpram_rr_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  a_req_valid;
  logic                  a_req_we;
  logic [ADDR_WIDTH-1:0] a_req_addr;
  logic [DATA_WIDTH-1:0] a_req_wdata;
  logic                  a_req_ready;
  logic                  a_rsp_valid;
  logic [DATA_WIDTH-1:0] a_rsp_rdata;

  logic                  b_req_valid;
  logic                  b_req_we;
  logic [ADDR_WIDTH-1:0] b_req_addr;
  logic [DATA_WIDTH-1:0] b_req_wdata;
  logic                  b_req_ready;
  logic                  b_rsp_valid;
  logic [DATA_WIDTH-1:0] b_rsp_rdata;

  logic                  mem_cs;
  logic                  mem_write_en;
  logic [ADDR_WIDTH-1:0] mem_write_addr;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic                  mem_read_en;
  logic [ADDR_WIDTH-1:0] mem_read_addr;
  logic [DATA_WIDTH-1:0] mem_read_data;

  modport master (
    output a_req_valid, a_req_we, a_req_addr, a_req_wdata,
    input  a_req_ready, a_rsp_valid, a_rsp_rdata,
    output b_req_valid, b_req_we, b_req_addr, b_req_wdata,
    input  b_req_ready, b_rsp_valid, b_rsp_rdata,
    input  mem_cs, mem_write_en, mem_write_addr, mem_write_data, mem_read_en, mem_read_addr,
    output mem_read_data
  );

  modport slave (
    input  a_req_valid, a_req_we, a_req_addr, a_req_wdata,
    output a_req_ready, a_rsp_valid, a_rsp_rdata,
    input  b_req_valid, b_req_we, b_req_addr, b_req_wdata,
    output b_req_ready, b_rsp_valid, b_rsp_rdata,
    output mem_cs, mem_write_en, mem_write_addr, mem_write_data, mem_read_en, mem_read_addr,
    input  mem_read_data
  );

endinterface

// File: rtl/dpram_rr_arbiter_rr_arb2.sv
// 2-way round-robin arbiter; grant is combinational, priority moves to the loser on each granting edge.
// Backpressure: the ungranted side just sees no grant and retries next cycle.
module rr_arb2
  import dpram_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_a_vld,
  input  logic req_b_vld,
  output logic gnt_vld,
  output logic gnt_id,
  output logic both_vld
);

  logic    prio_q;
  logic    prio_d;
  rr_gnt_t gnt;

  always_comb begin
    gnt      = rr_grant2(req_a_vld, req_b_vld, prio_q);
    gnt_vld  = gnt.vld;
    gnt_id   = gnt.id;
    both_vld = req_a_vld & req_b_vld;
    prio_d   = gnt.vld ? ~gnt.id : prio_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= REQ_A;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/dpram_rr_arbiter.sv
// Shares one 1W/1R RAM between requesters A and B; write and read ports arbitrated independently.
// Latency: requests go to the RAM combinationally, read data returns one cycle later; no response backpressure.
module dpram_rr_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dpram_rr_arbiter_if.slave    bus,
  output logic [CNT_WIDTH-1:0] contention_cnt
);

  logic a_wr_vld, a_rd_vld, b_wr_vld, b_rd_vld;
  logic wr_gnt_vld, wr_gnt_id, wr_both_vld;
  logic rd_gnt_vld, rd_gnt_id, rd_both_vld;

  logic                  rsp_pend_q, rsp_pend_d;
  logic                  rsp_id_q, rsp_id_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [DATA_WIDTH-1:0] wr_dat;

  always_comb begin
    a_wr_vld = bus.a_req_valid &  bus.a_req_we;
    a_rd_vld = bus.a_req_valid & ~bus.a_req_we;
    b_wr_vld = bus.b_req_valid &  bus.b_req_we;
    b_rd_vld = bus.b_req_valid & ~bus.b_req_we;
  end

  rr_arb2 u_wr_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_a_vld (a_wr_vld),
    .req_b_vld (b_wr_vld),
    .gnt_vld   (wr_gnt_vld),
    .gnt_id    (wr_gnt_id),
    .both_vld  (wr_both_vld)
  );

  rr_arb2 u_rd_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_a_vld (a_rd_vld),
    .req_b_vld (b_rd_vld),
    .gnt_vld   (rd_gnt_vld),
    .gnt_id    (rd_gnt_id),
    .both_vld  (rd_both_vld)
  );

  // A requester competes on exactly one port, chosen by its we bit.
  always_comb begin
    bus.a_req_ready = bus.a_req_we ? (wr_gnt_vld && wr_gnt_id == REQ_A)
                                   : (rd_gnt_vld && rd_gnt_id == REQ_A);
    bus.b_req_ready = bus.b_req_we ? (wr_gnt_vld && wr_gnt_id == REQ_B)
                                   : (rd_gnt_vld && rd_gnt_id == REQ_B);
  end

  // Idle ports drive zero address/data so the RAM bus is quiet.
  always_comb begin
    wr_addr = '0;
    wr_dat  = '0;
    rd_addr = '0;
    if (wr_gnt_vld) begin
      wr_addr = (wr_gnt_id == REQ_A) ? bus.a_req_addr  : bus.b_req_addr;
      wr_dat  = (wr_gnt_id == REQ_A) ? bus.a_req_wdata : bus.b_req_wdata;
    end
    if (rd_gnt_vld) begin
      rd_addr = (rd_gnt_id == REQ_A) ? bus.a_req_addr : bus.b_req_addr;
    end
    bus.mem_write_en   = wr_gnt_vld;
    bus.mem_write_addr = wr_addr;
    bus.mem_write_data = wr_dat;
    bus.mem_read_en    = rd_gnt_vld;
    bus.mem_read_addr  = rd_addr;
    bus.mem_cs         = wr_gnt_vld | rd_gnt_vld;
  end

  always_comb begin
    rsp_pend_d = rd_gnt_vld;
    rsp_id_d   = rd_gnt_vld ? rd_gnt_id : REQ_A;
    cnt_d      = cnt_q;
    if ((wr_both_vld || rd_both_vld) && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_pend_q <= 1'b0;
      rsp_id_q   <= REQ_A;
      cnt_q      <= '0;
    end else begin
      rsp_pend_q <= rsp_pend_d;
      rsp_id_q   <= rsp_id_d;
      cnt_q      <= cnt_d;
    end
  end

  // Registered RAM data is steered to whoever issued last cycle's read.
  always_comb begin
    bus.a_rsp_valid = rsp_pend_q && (rsp_id_q == REQ_A);
    bus.b_rsp_valid = rsp_pend_q && (rsp_id_q == REQ_B);
    bus.a_rsp_rdata = bus.a_rsp_valid ? bus.mem_read_data : '0;
    bus.b_rsp_rdata = bus.b_rsp_valid ? bus.mem_read_data : '0;
    contention_cnt  = cnt_q;
  end

endmodule

// File: tb/tb_dpram_rr_arbiter.sv
// Bench for dpram_rr_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_dpram_rr_arbiter;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int CW = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] contention_cnt;
  int            checks   = 0;
  int            failures = 0;

  dpram_rr_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  dpram_rr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .contention_cnt (contention_cnt)
  );

  always #5 clk = ~clk;

  // Simple read-before-write RAM with registered read data.
  logic [DW-1:0] ram [256];
  logic [DW-1:0] ram_rd_q = '0;
  always @(posedge clk) begin
    if (bus.mem_cs && bus.mem_read_en)  ram_rd_q <= ram[bus.mem_read_addr];
    if (bus.mem_cs && bus.mem_write_en) ram[bus.mem_write_addr] <= bus.mem_write_data;
  end
  assign bus.mem_read_data = ram_rd_q;

  task automatic drive(input bit side, input logic v, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    if (side == 1'b0) begin
      bus.a_req_valid = v; bus.a_req_we = we; bus.a_req_addr = ad; bus.a_req_wdata = d;
    end else begin
      bus.b_req_valid = v; bus.b_req_we = we; bus.b_req_addr = ad; bus.b_req_wdata = d;
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_dut();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #1;
    checks++; if (bus.a_rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_a_rsp_valid act=%0b exp=0", bus.a_rsp_valid); end
    checks++; if (bus.b_rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_b_rsp_valid act=%0b exp=0", bus.b_rsp_valid); end
    checks++; if (contention_cnt !== 4'd0) begin failures++; $display("FAIL rst_cnt act=%0d exp=0", contention_cnt); end
    checks++; if (bus.mem_cs !== 1'b0) begin failures++; $display("FAIL rst_mem_cs act=%0b exp=0", bus.mem_cs); end
    cyc();
    rst_n = 1'b1;
    #1;
    checks++; if (bus.a_req_ready !== 1'b0) begin failures++; $display("FAIL rst_a_ready act=%0b exp=0", bus.a_req_ready); end
    checks++; if (bus.b_rsp_rdata !== 32'h0) begin failures++; $display("FAIL rst_b_rdata act=%0h exp=0", bus.b_rsp_rdata); end
  endtask

  task automatic test_write_read();
    reset_dut();
    drive(1'b0, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF);
    #1;
    checks++; if (bus.a_req_ready !== 1'b1) begin failures++; $display("FAIL wr_a_ready act=%0b exp=1", bus.a_req_ready); end
    checks++; if (bus.mem_write_en !== 1'b1 || bus.mem_cs !== 1'b1 || bus.mem_read_en !== 1'b0) begin failures++; $display("FAIL wr_mem_en act=we%0b cs%0b re%0b exp=we1 cs1 re0", bus.mem_write_en, bus.mem_cs, bus.mem_read_en); end
    checks++; if (bus.mem_write_addr !== 8'h10 || bus.mem_write_data !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_mem_bus act=%0h/%0h exp=10/deadbeef", bus.mem_write_addr, bus.mem_write_data); end
    cyc();
    drive(1'b0, 1'b1, 1'b0, 8'h10, '0);
    #1;
    checks++; if (bus.a_req_ready !== 1'b1) begin failures++; $display("FAIL rd_a_ready act=%0b exp=1", bus.a_req_ready); end
    checks++; if (bus.mem_read_en !== 1'b1 || bus.mem_read_addr !== 8'h10) begin failures++; $display("FAIL rd_mem_bus act=%0b/%0h exp=1/10", bus.mem_read_en, bus.mem_read_addr); end
    checks++; if (bus.mem_write_addr !== 8'h0 || bus.mem_write_data !== 32'h0) begin failures++; $display("FAIL rd_idle_wr_bus act=%0h/%0h exp=0/0", bus.mem_write_addr, bus.mem_write_data); end
    checks++; if (bus.a_rsp_valid !== 1'b0) begin failures++; $display("FAIL wr_no_rsp act=%0b exp=0", bus.a_rsp_valid); end
    cyc();
    idle();
    #1;
    checks++; if (bus.a_rsp_valid !== 1'b1 || bus.a_rsp_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_a_rsp act=%0b/%0h exp=1/deadbeef", bus.a_rsp_valid, bus.a_rsp_rdata); end
    checks++; if (bus.b_rsp_valid !== 1'b0 || bus.b_rsp_rdata !== 32'h0) begin failures++; $display("FAIL rd_b_quiet act=%0b/%0h exp=0/0", bus.b_rsp_valid, bus.b_rsp_rdata); end
    cyc();
    #1;
    checks++; if (bus.a_rsp_valid !== 1'b0 || bus.a_rsp_rdata !== 32'h0) begin failures++; $display("FAIL rd_a_rsp_drop act=%0b/%0h exp=0/0", bus.a_rsp_valid, bus.a_rsp_rdata); end
  endtask

  task automatic test_write_contention();
    bit exp_a;
    reset_dut();
    drive(1'b0, 1'b1, 1'b1, 8'h01, 32'hA1);
    drive(1'b1, 1'b1, 1'b1, 8'h02, 32'hB2);
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_a = (i % 2 == 0);
      checks++; if (bus.a_req_ready !== exp_a || bus.b_req_ready !== !exp_a) begin failures++; $display("FAIL wc_grant%0d act=a%0b b%0b exp=a%0b b%0b", i, bus.a_req_ready, bus.b_req_ready, exp_a, !exp_a); end
      checks++; if (bus.mem_write_addr !== (exp_a ? 8'h01 : 8'h02)) begin failures++; $display("FAIL wc_addr%0d act=%0h exp=%0h", i, bus.mem_write_addr, exp_a ? 8'h01 : 8'h02); end
      cyc();
    end
    idle();
    #1;
    checks++; if (contention_cnt !== 4'd4) begin failures++; $display("FAIL wc_cnt act=%0d exp=4", contention_cnt); end
  endtask

  task automatic test_same_addr();
    reset_dut();
    drive(1'b0, 1'b1, 1'b1, 8'h20, 32'h11);
    cyc();
    drive(1'b0, 1'b1, 1'b1, 8'h20, 32'h55);
    drive(1'b1, 1'b1, 1'b0, 8'h20, '0);
    #1;
    checks++; if (bus.a_req_ready !== 1'b1 || bus.b_req_ready !== 1'b1) begin failures++; $display("FAIL sa_ready act=a%0b b%0b exp=a1 b1", bus.a_req_ready, bus.b_req_ready); end
    checks++; if (bus.mem_write_en !== 1'b1 || bus.mem_read_en !== 1'b1 || bus.mem_cs !== 1'b1) begin failures++; $display("FAIL sa_mem_en act=we%0b re%0b cs%0b exp=1 1 1", bus.mem_write_en, bus.mem_read_en, bus.mem_cs); end
    cyc();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    checks++; if (bus.b_rsp_valid !== 1'b1 || bus.b_rsp_rdata !== 32'h11) begin failures++; $display("FAIL sa_old_data act=%0b/%0h exp=1/11", bus.b_rsp_valid, bus.b_rsp_rdata); end
    checks++; if (bus.a_rsp_valid !== 1'b0) begin failures++; $display("FAIL sa_a_quiet act=%0b exp=0", bus.a_rsp_valid); end
    cyc();
    idle();
    #1;
    checks++; if (bus.b_rsp_valid !== 1'b1 || bus.b_rsp_rdata !== 32'h55) begin failures++; $display("FAIL sa_new_data act=%0b/%0h exp=1/55", bus.b_rsp_valid, bus.b_rsp_rdata); end
    checks++; if (contention_cnt !== 4'd0) begin failures++; $display("FAIL sa_cnt act=%0d exp=0", contention_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [3];
    logic [DW-1:0] dats  [3];
    addrs[0] = 8'h00; addrs[1] = 8'hFF; addrs[2] = 8'h7F;
    dats[0] = 32'hC0DE0000; dats[1] = 32'hC0DE00FF; dats[2] = 32'hC0DE007F;
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, addrs[i], dats[i]);
      #1;
      checks++; if (bus.mem_write_addr !== addrs[i]) begin failures++; $display("FAIL bb_wr_addr%0d act=%0h exp=%0h", i, bus.mem_write_addr, addrs[i]); end
      cyc();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(1'b1, 1'b1, 1'b0, addrs[i], '0);
      else       idle();
      #1;
      if (i < 3) begin
        checks++; if (bus.mem_cs !== 1'b1 || bus.mem_read_addr !== addrs[i] || bus.b_req_ready !== 1'b1) begin failures++; $display("FAIL bb_issue%0d act=cs%0b addr%0h rdy%0b exp=cs1 addr%0h rdy1", i, bus.mem_cs, bus.mem_read_addr, bus.b_req_ready, addrs[i]); end
      end else begin
        checks++; if (bus.mem_cs !== 1'b0) begin failures++; $display("FAIL bb_cs_idle act=%0b exp=0", bus.mem_cs); end
      end
      if (i > 0) begin
        checks++; if (bus.b_rsp_valid !== 1'b1 || bus.b_rsp_rdata !== dats[i-1]) begin failures++; $display("FAIL bb_rsp%0d act=%0b/%0h exp=1/%0h", i - 1, bus.b_rsp_valid, bus.b_rsp_rdata, dats[i-1]); end
      end else begin
        checks++; if (bus.b_rsp_valid !== 1'b0) begin failures++; $display("FAIL bb_rsp_early act=%0b exp=0", bus.b_rsp_valid); end
      end
      cyc();
    end
    #1;
    checks++; if (bus.b_rsp_valid !== 1'b0) begin failures++; $display("FAIL bb_rsp_tail act=%0b exp=0", bus.b_rsp_valid); end
  endtask

  task automatic test_reset_inflight();
    reset_dut();
    drive(1'b0, 1'b1, 1'b1, 8'h05, 32'h5);
    drive(1'b1, 1'b1, 1'b1, 8'h06, 32'h6);
    cyc();
    drive(1'b0, 1'b1, 1'b0, 8'h10, '0);
    drive(1'b1, 1'b1, 1'b0, 8'h40, '0);
    #1;
    checks++; if (bus.a_req_ready !== 1'b1 || bus.b_req_ready !== 1'b0) begin failures++; $display("FAIL ri_rd_grant act=a%0b b%0b exp=a1 b0", bus.a_req_ready, bus.b_req_ready); end
    @(posedge clk);
    #2;
    checks++; if (bus.a_rsp_valid !== 1'b1) begin failures++; $display("FAIL ri_inflight act=%0b exp=1", bus.a_rsp_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.a_rsp_valid !== 1'b0 || bus.a_rsp_rdata !== 32'h0) begin failures++; $display("FAIL ri_async_drop act=%0b/%0h exp=0/0", bus.a_rsp_valid, bus.a_rsp_rdata); end
    checks++; if (contention_cnt !== 4'd0) begin failures++; $display("FAIL ri_cnt_clr act=%0d exp=0", contention_cnt); end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.a_rsp_valid !== 1'b0 || bus.b_rsp_valid !== 1'b0) begin failures++; $display("FAIL ri_no_rsp0 act=a%0b b%0b exp=0 0", bus.a_rsp_valid, bus.b_rsp_valid); end
    cyc();
    drive(1'b0, 1'b1, 1'b1, 8'h05, 32'h5);
    drive(1'b1, 1'b1, 1'b1, 8'h06, 32'h6);
    #1;
    checks++; if (bus.a_rsp_valid !== 1'b0 || bus.b_rsp_valid !== 1'b0) begin failures++; $display("FAIL ri_no_rsp1 act=a%0b b%0b exp=0 0", bus.a_rsp_valid, bus.b_rsp_valid); end
    checks++; if (bus.a_req_ready !== 1'b1 || bus.b_req_ready !== 1'b0) begin failures++; $display("FAIL ri_wr_prio act=a%0b b%0b exp=a1 b0", bus.a_req_ready, bus.b_req_ready); end
    cyc();
    drive(1'b0, 1'b1, 1'b0, 8'h05, '0);
    drive(1'b1, 1'b1, 1'b0, 8'h06, '0);
    #1;
    checks++; if (bus.a_req_ready !== 1'b1 || bus.b_req_ready !== 1'b0) begin failures++; $display("FAIL ri_rd_prio act=a%0b b%0b exp=a1 b0", bus.a_req_ready, bus.b_req_ready); end
    cyc();
    idle();
    #1;
    checks++; if (contention_cnt !== 4'd2) begin failures++; $display("FAIL ri_cnt act=%0d exp=2", contention_cnt); end
  endtask

  task automatic test_saturation();
    int exp_cnt;
    reset_dut();
    drive(1'b0, 1'b1, 1'b1, 8'h33, 32'h1);
    drive(1'b1, 1'b1, 1'b1, 8'h44, 32'h2);
    for (int i = 0; i < 20; i++) begin
      cyc();
      #1;
      exp_cnt = (i + 1 > 15) ? 15 : i + 1;
      checks++; if (contention_cnt !== CW'(exp_cnt)) begin failures++; $display("FAIL sat_cnt%0d act=%0d exp=%0d", i, contention_cnt, exp_cnt); end
    end
    idle();
  endtask

  task automatic test_random();
    logic [DW-1:0] sh [8];
    logic          pv  [2];
    logic          pwe [2];
    logic [AW-1:0] pad [2];
    logic [DW-1:0] pd  [2];
    logic          acc [2];
    int            wr_prio, rd_prio, cnt, rsp_who, wwin, rwin;
    logic [DW-1:0] rsp_dat;
    bit            wc0, wc1, rc0, rc1;
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      sh[i] = $urandom;
      drive(1'b0, 1'b1, 1'b1, AW'(248 + i), sh[i]);
      cyc();
    end
    reset_dut();
    wr_prio = 0; rd_prio = 0; cnt = 0; rsp_who = -1; rsp_dat = '0;
    for (int s = 0; s < 2; s++) begin
      pv[s] = 1'b0; pwe[s] = 1'b0; pad[s] = '0; pd[s] = '0; acc[s] = 1'b1;
    end
    for (int c = 0; c < 400; c++) begin
      // A stalled request is held unchanged until accepted.
      for (int s = 0; s < 2; s++) begin
        if (!pv[s] || acc[s]) begin
          pv[s]  = ($urandom_range(0, 3) != 0);
          pwe[s] = 1'($urandom_range(0, 1));
          pad[s] = AW'(248 + $urandom_range(0, 7));
          pd[s]  = $urandom;
        end
      end
      drive(1'b0, pv[0], pwe[0], pad[0], pd[0]);
      drive(1'b1, pv[1], pwe[1], pad[1], pd[1]);
      #1;
      wc0 = pv[0] && pwe[0]; wc1 = pv[1] && pwe[1];
      rc0 = pv[0] && !pwe[0]; rc1 = pv[1] && !pwe[1];
      wwin = (wc0 && wc1) ? wr_prio : wc0 ? 0 : wc1 ? 1 : -1;
      rwin = (rc0 && rc1) ? rd_prio : rc0 ? 0 : rc1 ? 1 : -1;
      acc[0] = (wwin == 0) || (rwin == 0);
      acc[1] = (wwin == 1) || (rwin == 1);
      checks++; if (bus.a_req_ready !== acc[0] || bus.b_req_ready !== acc[1]) begin failures++; $display("FAIL rnd_ready c%0d act=a%0b b%0b exp=a%0b b%0b", c, bus.a_req_ready, bus.b_req_ready, acc[0], acc[1]); end
      checks++; if (bus.mem_cs !== (wwin >= 0 || rwin >= 0)) begin failures++; $display("FAIL rnd_cs c%0d act=%0b exp=%0b", c, bus.mem_cs, (wwin >= 0 || rwin >= 0)); end
      checks++; if (bus.mem_write_addr !== ((wwin >= 0) ? pad[wwin] : '0) || bus.mem_write_data !== ((wwin >= 0) ? pd[wwin] : '0)) begin failures++; $display("FAIL rnd_wr_bus c%0d act=%0h/%0h win=%0d", c, bus.mem_write_addr, bus.mem_write_data, wwin); end
      checks++; if (bus.mem_read_addr !== ((rwin >= 0) ? pad[rwin] : '0)) begin failures++; $display("FAIL rnd_rd_addr c%0d act=%0h win=%0d", c, bus.mem_read_addr, rwin); end
      checks++; if (bus.a_rsp_valid !== (rsp_who == 0) || bus.a_rsp_rdata !== ((rsp_who == 0) ? rsp_dat : '0)) begin failures++; $display("FAIL rnd_a_rsp c%0d act=%0b/%0h exp=%0b/%0h", c, bus.a_rsp_valid, bus.a_rsp_rdata, (rsp_who == 0), rsp_dat); end
      checks++; if (bus.b_rsp_valid !== (rsp_who == 1) || bus.b_rsp_rdata !== ((rsp_who == 1) ? rsp_dat : '0)) begin failures++; $display("FAIL rnd_b_rsp c%0d act=%0b/%0h exp=%0b/%0h", c, bus.b_rsp_valid, bus.b_rsp_rdata, (rsp_who == 1), rsp_dat); end
      checks++; if (contention_cnt !== CW'(cnt)) begin failures++; $display("FAIL rnd_cnt c%0d act=%0d exp=%0d", c, contention_cnt, cnt); end
      @(posedge clk);
      // Reads see memory as it was before this cycle's write.
      rsp_who = rwin;
      rsp_dat = (rwin >= 0) ? sh[pad[rwin][2:0]] : '0;
      if (wwin >= 0) sh[pad[wwin][2:0]] = pd[wwin];
      if (wwin >= 0) wr_prio = 1 - wwin;
      if (rwin >= 0) rd_prio = 1 - rwin;
      if (((wc0 && wc1) || (rc0 && rc1)) && cnt < 15) cnt++;
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_write_read();
    test_write_contention();
    test_same_addr();
    test_back_to_back();
    test_reset_inflight();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
